// File: rtl/branch_ctrl_pkg.sv
// Shared types and constants for the branch waterfall queue controller.
package branch_ctrl_pkg;

    // Controller sequencing states.
    typedef enum logic [1:0] {
        INIT   = 2'd0,
        RUN    = 2'd1,
        FLUSH  = 2'd2,
        REFILL = 2'd3
    } bq_state_t;

    // Number of entries in the branch waterfall queue.
    localparam int BQ_DEPTH = 3;

    // Program counter / mispredict address type.
    typedef logic [15:0] pc_t;

endpackage

// File: rtl/branch_queue_controller.sv
// Branch queue controller: turns fetch-side predictions and execute-side
// resolutions into load/update/correct strobes for the 3-entry branch
// waterfall queue, tracks occupancy, and sequences flush/redirect/refill
// after a mispredict.
module branch_queue_controller
    import branch_ctrl_pkg::*;
#(
    parameter int DEPTH         = BQ_DEPTH,
    parameter int REFILL_CYCLES = 2,
    parameter int ADDR_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              fetch_branch_valid,
    input  logic              fetch_prediction,
    input  logic [ADDR_W-1:0] fetch_alt_address,
    input  logic              resolve_valid,
    input  logic              resolve_taken,
    input  logic [ADDR_W-1:0] q_mispredict_address,
    input  logic              q_prediction,
    output logic              q_load,
    output logic              q_update,
    output logic              q_correct,
    output logic              q_prediction_in,
    output logic [ADDR_W-1:0] q_address_in,
    output logic              fetch_hold,
    output logic              flush,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_address,
    output logic [1:0]        occupancy,
    output logic              err
);

    // State encodings as plain vectors so the state register is a simple logic.
    localparam logic [1:0] S_INIT   = INIT;
    localparam logic [1:0] S_RUN    = RUN;
    localparam logic [1:0] S_FLUSH  = FLUSH;
    localparam logic [1:0] S_REFILL = REFILL;

    // Counter only has to hold REFILL_CYCLES-1.
    localparam int CNT_W = (REFILL_CYCLES > 1) ? $clog2(REFILL_CYCLES) : 1;

    localparam logic [1:0] OCC_FULL = 2'(DEPTH);

    logic [1:0]       state;
    logic [CNT_W-1:0] refill_cnt;

    logic correct_c;
    logic in_run;
    logic full;
    logic res;
    logic accept;
    logic mispredict;
    logic proto_err;

    // Strobe, hold and redirect generation; everything here is same-cycle.
    always_comb begin
        correct_c  = (resolve_taken == q_prediction);
        in_run     = (state == S_RUN);
        full       = (occupancy == OCC_FULL);
        // A resolve is only honoured in RUN with something outstanding.
        res        = resolve_valid & (occupancy != 2'd0) & in_run & ~stall;
        mispredict = res & ~correct_c;
        // Outputs stay quiet while reset is held, including the INIT strobe.
        fetch_hold = ~rst & (~in_run | (full & ~(res & correct_c)));
        accept     = fetch_branch_valid & ~fetch_hold & ~stall;
        proto_err  = resolve_valid & ~stall & ((occupancy == 2'd0) | ~in_run);

        q_load          = accept & ~mispredict;
        // INIT forces an update with correct=0 to scrub the unreset queue.
        q_update        = res | ((state == S_INIT) & ~stall & ~rst);
        q_correct       = res & correct_c;
        q_prediction_in = fetch_prediction;
        q_address_in    = fetch_alt_address;

        flush            = mispredict | ((state == S_FLUSH) & ~stall);
        redirect_valid   = mispredict;
        redirect_address = mispredict ? q_mispredict_address : '0;
    end

    // FSM, refill counter, occupancy counter and sticky error; stall freezes all.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_INIT;
            refill_cnt <= '0;
            occupancy  <= 2'd0;
            err        <= 1'b0;
        end else if (!stall) begin
            if (proto_err) begin
                err <= 1'b1;
            end
            case (state)
                S_INIT: begin
                    state <= S_RUN;
                end
                S_RUN: begin
                    if (mispredict) begin
                        // Everything younger than the bad branch is discarded.
                        occupancy <= 2'd0;
                        state     <= S_FLUSH;
                    end else if (res && q_load) begin
                        occupancy <= occupancy;
                    end else if (res) begin
                        occupancy <= occupancy - 2'd1;
                    end else if (q_load) begin
                        occupancy <= occupancy + 2'd1;
                    end
                end
                S_FLUSH: begin
                    state      <= S_REFILL;
                    refill_cnt <= CNT_W'(REFILL_CYCLES - 1);
                end
                S_REFILL: begin
                    if (refill_cnt == '0) begin
                        state <= S_RUN;
                    end else begin
                        refill_cnt <= refill_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= S_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_queue_controller.sv
// Self-checking bench for branch_queue_controller: a vector table pushed
// through a scoreboard, plus hand-written reset and stall sequences.
module tb_branch_queue_controller;

    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              stall = 1'b0;
    logic              fetch_branch_valid = 1'b0;
    logic              fetch_prediction = 1'b0;
    logic [ADDR_W-1:0] fetch_alt_address = '0;
    logic              resolve_valid = 1'b0;
    logic              resolve_taken = 1'b0;
    logic [ADDR_W-1:0] q_mispredict_address = '0;
    logic              q_prediction = 1'b0;
    logic              q_load;
    logic              q_update;
    logic              q_correct;
    logic              q_prediction_in;
    logic [ADDR_W-1:0] q_address_in;
    logic              fetch_hold;
    logic              flush;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_address;
    logic [1:0]        occupancy;
    logic              err;

    int checks = 0;
    int errors = 0;

    branch_queue_controller #(
        .DEPTH(3), .REFILL_CYCLES(2), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .fetch_branch_valid(fetch_branch_valid),
        .fetch_prediction(fetch_prediction),
        .fetch_alt_address(fetch_alt_address),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
        .q_mispredict_address(q_mispredict_address),
        .q_prediction(q_prediction),
        .q_load(q_load), .q_update(q_update), .q_correct(q_correct),
        .q_prediction_in(q_prediction_in), .q_address_in(q_address_in),
        .fetch_hold(fetch_hold), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_address(redirect_address),
        .occupancy(occupancy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st, fv, fp;
        logic [15:0] fa;
        logic        rv, rt, qp;
        logic [15:0] qa;
        logic [24:0] ex;
    } vec_t;

    vec_t tbl [24];
    logic [41:0] exp_q [$];

    // Expected outputs: load, update, correct, hold, flush, redirect_valid, redirect_address, occupancy, err
    function automatic logic [24:0] e(logic ld, logic up, logic co, logic ho, logic fl,
                                      logic rd, logic [15:0] ra, logic [1:0] oc, logic er);
        return {ld, up, co, ho, fl, rd, ra, oc, er};
    endfunction

    function automatic vec_t r(logic st, logic fv, logic fp, logic [15:0] fa, logic rv,
                               logic rt, logic qp, logic [15:0] qa, logic [24:0] ex);
        vec_t v;
        v.st = st; v.fv = fv; v.fp = fp; v.fa = fa;
        v.rv = rv; v.rt = rt; v.qp = qp; v.qa = qa; v.ex = ex;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
        end
    endtask

    function automatic logic [41:0] outs();
        return {q_load, q_update, q_correct, fetch_hold, flush, redirect_valid,
                redirect_address, occupancy, err, q_prediction_in, q_address_in};
    endfunction

    // Drive one vector, queue its expectation, compare at the falling edge.
    task automatic apply(input vec_t v, input int idx);
        logic [41:0] expv;
        stall = v.st; fetch_branch_valid = v.fv; fetch_prediction = v.fp;
        fetch_alt_address = v.fa; resolve_valid = v.rv; resolve_taken = v.rt;
        q_prediction = v.qp; q_mispredict_address = v.qa;
        exp_q.push_back({v.ex, v.fp, v.fa});
        @(negedge clk);
        if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_empty row %0d: got 0 entries expected 1", idx);
        end else begin
            expv = exp_q.pop_front();
            chk($sformatf("row%0d", idx), 64'(outs()), 64'(expv));
        end
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs();
        stall = 0; fetch_branch_valid = 0; fetch_prediction = 0; fetch_alt_address = '0;
        resolve_valid = 0; resolve_taken = 0; q_prediction = 0; q_mispredict_address = '0;
    endtask

    initial begin
        tbl[0]  = r(0,0,0,16'h0000,0,0,0,16'h0000, e(0,1,0,1,0,0,16'h0000,2'd0,0)); // INIT scrub
        tbl[1]  = r(0,1,1,16'h1000,0,0,0,16'h0000, e(1,0,0,0,0,0,16'h0000,2'd0,0));
        tbl[2]  = r(0,1,0,16'h2000,0,0,0,16'h0000, e(1,0,0,0,0,0,16'h0000,2'd1,0));
        tbl[3]  = r(0,1,1,16'h3000,0,0,0,16'h0000, e(1,0,0,0,0,0,16'h0000,2'd2,0));
        tbl[4]  = r(0,0,0,16'h0000,0,0,0,16'h0000, e(0,0,0,1,0,0,16'h0000,2'd3,0)); // full
        tbl[5]  = r(0,1,0,16'h4000,0,0,0,16'h0000, e(0,0,0,1,0,0,16'h0000,2'd3,0)); // rejected
        tbl[6]  = r(0,1,1,16'h4000,1,1,1,16'h1000, e(1,1,1,0,0,0,16'h0000,2'd3,0)); // load+resolve full
        tbl[7]  = r(0,0,0,16'h0000,0,0,0,16'h0000, e(0,0,0,1,0,0,16'h0000,2'd3,0));
        tbl[8]  = r(0,0,0,16'h0000,1,0,0,16'h2000, e(0,1,1,0,0,0,16'h0000,2'd3,0)); // correct not-taken
        tbl[9]  = r(0,0,0,16'h0000,0,0,0,16'h0000, e(0,0,0,0,0,0,16'h0000,2'd2,0));
        tbl[10] = r(0,1,0,16'h5000,1,0,1,16'h1000, e(0,1,0,0,1,1,16'h1000,2'd2,0)); // mispredict
        tbl[11] = r(0,1,0,16'h5000,0,0,0,16'h0000, e(0,0,0,1,1,0,16'h0000,2'd0,0)); // FLUSH
        tbl[12] = r(0,1,0,16'h5000,0,0,0,16'h0000, e(0,0,0,1,0,0,16'h0000,2'd0,0)); // REFILL 1
        tbl[13] = r(0,1,0,16'h5000,0,0,0,16'h0000, e(0,0,0,1,0,0,16'h0000,2'd0,0)); // REFILL 2
        tbl[14] = r(0,1,1,16'h6000,0,0,0,16'h0000, e(1,0,0,0,0,0,16'h0000,2'd0,0)); // back in RUN
        for (int i = 15; i < 19; i++)
            tbl[i] = r(1,0,0,16'h0000,1,1,1,16'h6000, e(0,0,0,0,0,0,16'h0000,2'd1,0)); // stalled
        tbl[19] = r(0,0,0,16'h0000,1,1,1,16'h6000, e(0,1,1,0,0,0,16'h0000,2'd1,0));
        tbl[20] = r(0,0,0,16'h0000,0,0,0,16'h0000, e(0,0,0,0,0,0,16'h0000,2'd0,0));
        tbl[21] = r(0,0,0,16'h0000,1,1,1,16'h0000, e(0,0,0,0,0,0,16'h0000,2'd0,0)); // resolve when empty
        tbl[22] = r(0,0,0,16'h0000,0,0,0,16'h0000, e(0,0,0,0,0,0,16'h0000,2'd0,1));
        tbl[23] = r(0,1,1,16'h7000,0,0,0,16'h0000, e(1,0,0,0,0,0,16'h0000,2'd0,1));

        // Reset held: everything at reset values.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_occupancy", 64'(occupancy), 64'd0);
        chk("reset_err", 64'(err), 64'd0);
        chk("reset_strobes", 64'({q_load, q_update, q_correct, flush, redirect_valid}), 64'd0);
        chk("reset_fetch_hold", 64'(fetch_hold), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 24; i++) apply(tbl[i], i);

        // err stays set across idle cycles.
        idle_inputs();
        repeat (2) begin
            @(negedge clk);
            chk("err_sticky", 64'(err), 64'd1);
            @(posedge clk); #1;
        end
        chk("occupancy_before_async_rst", 64'(occupancy), 64'd1);

        // Asynchronous reset mid-cycle takes effect immediately.
        #2 rst = 1'b1;
        #1;
        chk("async_rst_occupancy", 64'(occupancy), 64'd0);
        chk("async_rst_err", 64'(err), 64'd0);
        chk("async_rst_outputs", 64'({q_update, fetch_hold, q_load}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        stall = 1'b1;

        // INIT is held by stall and only fires on the first unstalled cycle.
        repeat (2) begin
            @(negedge clk);
            chk("init_stalled", 64'({q_update, q_correct, fetch_hold}), 64'b001);
            @(posedge clk); #1;
        end
        stall = 1'b0;
        @(negedge clk);
        chk("init_release", 64'({q_update, q_correct, fetch_hold}), 64'b101);
        @(posedge clk); #1;
        @(negedge clk);
        chk("run_after_init", 64'({q_update, fetch_hold, occupancy}), 64'd0);

        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard bound on run time.
    initial begin
        #100000;
        $display("FAIL timeout: got no completion expected finish before 100000");
        $fatal(1);
    end

endmodule
